// File: rtl/gray_decoder_if.sv
// Gray stream from the counter into the decoder, plus the decoder's status.
// The slave modport is the decoder side; the master modport is the producer/observer side.
interface gray_decoder_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
);
  logic              Valid;
  logic [WIDTH-1:0]  Gray;
  logic              OvfIn;
  logic              Resync;
  logic [WIDTH-1:0]  Binary;
  logic              Locked;
  logic              Step;
  logic              Wrap;
  logic [WRAP_W-1:0] WrapCnt;
  logic              Error;
  logic              Down;

  modport master (
    output Valid, Gray, OvfIn, Resync,
    input  Binary, Locked, Step, Wrap, WrapCnt, Error, Down
  );
  modport slave (
    input  Valid, Gray, OvfIn, Resync,
    output Binary, Locked, Step, Wrap, WrapCnt, Error, Down
  );
endinterface

// File: rtl/gray_decoder.sv
// Gray-to-binary receiver: acquires, tracks single-step advances, counts wraps and latches protocol errors.
// Optional macro GRAY_DEC_BIDIR_EN also accepts -1 steps (Down pulse, underflow decrements WrapCnt).
module gray_decoder #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  gray_decoder_if.slave bus
);
  typedef enum logic [1:0] {ACQ, TRACK, ERR} state_t;

  localparam logic [WIDTH-1:0]  BMAX    = '1;
  localparam logic [WRAP_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [WIDTH-1:0]  dec, inc, binary;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              locked, step, wrap, error;

  // Binary bit i is the XOR of all Gray bits at or above i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign dec[i] = ^(bus.Gray >> i);
  end

  assign inc = binary + 1'b1;

`ifdef GRAY_DEC_BIDIR_EN
  logic [WIDTH-1:0] dcr;
  logic             down;
  assign dcr = binary - 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ACQ;
      binary   <= '0;
      locked   <= 1'b0;
      step     <= 1'b0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
      error    <= 1'b0;
`ifdef GRAY_DEC_BIDIR_EN
      down     <= 1'b0;
`endif
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
`ifdef GRAY_DEC_BIDIR_EN
      down <= 1'b0;
`endif
      if (bus.Resync) begin
        // A sample arriving with Resync is deliberately dropped.
        state    <= ACQ;
        error    <= 1'b0;
        locked   <= 1'b0;
        wrap_cnt <= '0;
      end else begin
        case (state)
          ACQ: if (bus.Valid) begin
            binary <= dec;
            locked <= 1'b1;
            state  <= TRACK;
          end
          TRACK: if (bus.Valid) begin
            if (dec == binary) begin
              // repeat of the current value: nothing to do
            end else if (dec == inc) begin
              binary <= dec;
              step   <= 1'b1;
              if (binary == BMAX) begin
                wrap <= 1'b1;
                if (wrap_cnt != CNT_MAX) wrap_cnt <= wrap_cnt + 1'b1;
              end
              // The advance is kept even when the overflow flag disagrees.
              if (bus.OvfIn != (binary == BMAX)) begin
                error <= 1'b1;
                state <= ERR;
              end
`ifdef GRAY_DEC_BIDIR_EN
            end else if (dec == dcr) begin
              binary <= dec;
              down   <= 1'b1;
              if (binary == '0) begin
                wrap <= 1'b1;
                if (wrap_cnt != '0) wrap_cnt <= wrap_cnt - 1'b1;
              end
              if (bus.OvfIn != (binary == '0)) begin
                error <= 1'b1;
                state <= ERR;
              end
`endif
            end else begin
              error  <= 1'b1;
              locked <= 1'b0;
              state  <= ERR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Binary  = binary;
  assign bus.Locked  = locked;
  assign bus.Step    = step;
  assign bus.Wrap    = wrap;
  assign bus.WrapCnt = wrap_cnt;
  assign bus.Error   = error;
`ifdef GRAY_DEC_BIDIR_EN
  assign bus.Down    = down;
`else
  assign bus.Down    = 1'b0;
`endif
endmodule

// File: doc/gray_decoder.md
Name: gray_decoder

Overview:
- Receiving end of the 3-bit Gray counter interface: samples the Gray code stream (Output/Overflow of the counter) and converts it back to binary.
- Checks that every change is a legal single-step advance, counts wrap-arounds and flags protocol errors.
- Sits downstream of the Gray counter; drives binary consumers and status logic.

Parameters:
- WIDTH, 3, Gray/binary code width; the counter modulus is 2^WIDTH.
- WRAP_W, 4, width of the wrap counter, which saturates at 2^WRAP_W-1.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Valid  input  1  Gray and OvfIn are sampled this cycle.
- Gray  input  WIDTH  Gray-coded count from the counter.
- OvfIn  input  1  overflow flag from the counter, checked against decoded wrap.
- Resync  input  1  clear the error and re-acquire on the next Valid sample.
- Binary  output  WIDTH  decoded binary value of the last accepted sample.
- Locked  output  1  a reference value has been acquired and the decoder is tracking.
- Step  output  1  one-cycle pulse: last sample advanced by +1.
- Wrap  output  1  one-cycle pulse: last advance was 2^WIDTH-1 -> 0.
- WrapCnt  output  WRAP_W  number of wraps since reset or resync; saturating.
- Error  output  1  sticky: illegal transition or overflow mismatch seen.
- Down  output  1  one-cycle pulse: last sample stepped by -1 (only with the optional feature; otherwise tied 0).

Behaviour:
- Decode: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i]. Combinational on the Gray input; all outputs registered, so latency is 1 cycle after the Valid edge.
- Reset (synchronous, highest priority): state=ACQ; Binary=0, Locked=0, Step=0, Wrap=0, Down=0, WrapCnt=0, Error=0.
- Step, Wrap and Down default to 0 every cycle unless set below.
- State ACQ:
  - On Valid: Binary<=decoded value, Locked<=1, go TRACK.
  - No Step or Wrap pulse; OvfIn is not checked.
- State TRACK, on Valid (d = decoded value, p = Binary):
  - d==p: hold; no pulses.
  - d==p+1 (mod 2^W): Binary<=d, Step=1.
  - If additionally p==2^W-1: Wrap=1, WrapCnt+=1 (saturates at max).
  - OvfIn is checked only on an accepted advance: required value is 1 when Wrap fires, else 0. Mismatch -> Error=1, go ERR. Binary still updates.
  - Any other d (including 2-bit Gray changes): Error=1, Locked=0, go ERR; Binary unchanged.
- TRACK without Valid: everything holds.
- State ERR: ignores Valid; Error stays 1 and Binary holds.
- Resync (any state, lower priority than Reset): next state ACQ; Error=0, Locked=0, WrapCnt=0; Binary holds.
- Resync and Valid in the same cycle: Resync wins and the sample is discarded.
- Reset mid-stream: state returns to ACQ; the first Valid after reset re-acquires whatever value is present. No error is raised even if the counter itself was not reset.

Optional Feature:
- Macro: GRAY_DEC_BIDIR_EN.
- When defined: in TRACK, d==p-1 (mod 2^W) is legal. Binary<=d and Down=1.
  - The 0 -> 2^W-1 transition is an underflow: Wrap=1, and WrapCnt decrements, saturating at 0.
  - OvfIn must be 1 on that transition.
- When undefined: a -1 step is an illegal transition (Error, go ERR); Down is constant 0.

Test Plan:
1. Reset=1 for 1 cycle, then Valid with Gray 000,001,011,010,110,111,101,100,000 (one per cycle), OvfIn=1 only on the final 000 -> Binary follows 0..7,0 one cycle late. Step pulses on 8 samples. Wrap=1 once, WrapCnt=1, Error=0.
2. Lock at Gray 011 (Binary=2), then Valid Gray 110 (binary 4) -> Error=1 and Locked=0 next cycle, Binary stays 2. Further Valid samples are ignored.
3. From case 2's error, assert Resync, then Valid Gray 101 -> Error=0, WrapCnt=0, Locked=1, Binary=6, no Step.
4. Locked at Binary 7 (Gray 100), Valid Gray 000 with OvfIn=0 -> Binary=0, Step=1, Wrap=1, Error=1, state ERR.
5. Run 17 clean wraps with WRAP_W=4 -> WrapCnt saturates at 15. Assert Reset mid-sequence -> next-cycle WrapCnt=0, Binary=0, Locked=0. The next Valid Gray 010 locks Binary=3.
6. Locked at Binary 3 (Gray 010), Valid Gray 011 (binary 2):
   - GRAY_DEC_BIDIR_EN defined -> Binary=2, Down=1, Error=0.
   - Undefined -> Error=1.
